// File: rtl/gsim_param_if.sv
// Stream bundle for gsim_param: b-vector input side and solution output side.
// The source (testbench or upstream block) takes master, the solver takes slave.
interface gsim_param_if #(
    parameter int B_W = 16,
    parameter int X_W = 32
);
    logic                  in_en;
    logic signed [B_W-1:0] b_in;
    logic [7:0]            iter_cfg;
    logic                  tol_en;
    logic [X_W-1:0]        tol;
    logic                  busy;
    logic                  out_valid;
    logic signed [X_W-1:0] x_out;
    logic [7:0]            iter_used;

    modport master (
        output in_en,
        output b_in,
        output iter_cfg,
        output tol_en,
        output tol,
        input  busy,
        input  out_valid,
        input  x_out,
        input  iter_used
    );

    modport slave (
        input  in_en,
        input  b_in,
        input  iter_cfg,
        input  tol_en,
        input  tol,
        output busy,
        output out_valid,
        output x_out,
        output iter_used
    );
endinterface

// File: rtl/gsim_param.sv
// Gauss-Seidel solver for the 7-band Toeplitz system 20,-13,6,-1.
// Receives b, sweeps in place (3 cycles per unknown), then streams x out.
module gsim_param #(
    parameter int N      = 16,
    parameter int B_W    = 16,
    parameter int X_W    = 32,
    parameter int FRAC   = 16,
    parameter int DIV_K  = 3277,
    parameter int DIV_SH = 16
) (
    input  logic        clk,
    input  logic        reset,
    gsim_param_if.slave bus
);
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int XW1 = X_W + 1;
    localparam int BF  = B_W + FRAC;
    localparam int SW  = ((X_W > BF) ? X_W : BF) + 6;
    localparam int PW  = SW + 32;

    localparam logic [CW-1:0]         LAST = CW'(N - 1);
    localparam logic [CW:0]           NCNT = (CW + 1)'(N);
    localparam logic signed [31:0]    KMUL = 32'(DIV_K);
    localparam logic signed [X_W-1:0] XMAX = {1'b0, {(X_W - 1){1'b1}}};
    localparam logic signed [X_W-1:0] XMIN = {1'b1, {(X_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        RECV,
        CALC,
        SEND
    } state_t;

    function automatic logic signed [X_W-1:0] sat_x(
        input logic signed [PW-1:0] v
    );
        logic [PW-X_W:0] hi;
        hi = v[PW-1:X_W-1];
        if (&hi || ~|hi) begin
            return v[X_W-1:0];
        end
        return v[PW-1] ? XMIN : XMAX;
    endfunction

    state_t state;
    state_t state_nx;

    logic [CW-1:0]  cnt;
    logic [1:0]     ph;
    logic [7:0]     sweep;
    logic [7:0]     k_r;
    logic [7:0]     iter_used;
    logic           tol_en_r;
    logic [X_W-1:0] tol_r;
    logic [X_W-1:0] maxd;
    logic [X_W-1:0] maxd_nx;
    logic [X_W-1:0] ad;

    logic signed [B_W-1:0] b_mem [N];
    logic signed [X_W-1:0] x_mem [N];

    logic signed [X_W-1:0] nl [3];
    logic signed [X_W-1:0] nh [3];
    logic [CW:0]           up [3];

    logic signed [XW1-1:0] p1_r;
    logic signed [XW1-1:0] p2_r;
    logic signed [XW1-1:0] p3_r;
    logic signed [SW-1:0]  bsh_r;
    logic signed [X_W-1:0] xold_r;
    logic signed [SW-1:0]  s_sum;
    logic signed [PW-1:0]  prod_r;
    logic signed [X_W-1:0] x_new;
    logic signed [X_W-1:0] bx;
    logic signed [XW1-1:0] dlt;

    logic acc;
    logic wb;
    logic last_u;
    logic fin;

    // Neighbours at distance 1..3; anything outside 0..N-1 reads as zero.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            nl[k] = '0;
            nh[k] = '0;
            up[k] = {1'b0, cnt} + (CW + 1)'(k + 1);
            if (cnt > CW'(k)) begin
                nl[k] = x_mem[cnt - CW'(k + 1)];
            end
            if (up[k] < NCNT) begin
                nh[k] = x_mem[up[k][CW-1:0]];
            end
        end
    end

    always_comb begin
        s_sum = (SW'(p1_r) <<< 3) + (SW'(p1_r) <<< 2) + SW'(p1_r)
              - (SW'(p2_r) <<< 2) - (SW'(p2_r) <<< 1)
              + SW'(p3_r) + bsh_r;
        x_new   = sat_x(prod_r >>> DIV_SH);
        dlt     = XW1'(x_new) - XW1'(xold_r);
        ad      = dlt[X_W] ? X_W'(-dlt) : X_W'(dlt);
        maxd_nx = (ad > maxd) ? ad : maxd;
        bx      = sat_x(PW'(bus.b_in) <<< FRAC);
    end

    always_comb begin
        state_nx = state;
        acc      = 1'b0;
        wb       = 1'b0;
        last_u   = 1'b0;
        fin      = 1'b0;
        unique case (state)
            RECV: begin
                acc = bus.in_en;
                if (acc && cnt == LAST) begin
                    state_nx = CALC;
                end
            end
            CALC: begin
                wb     = (ph == 2'd2);
                last_u = wb && (cnt == LAST);
                fin    = last_u && ((sweep == k_r) ||
                         (tol_en_r && maxd_nx <= tol_r));
                if (fin) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (cnt == LAST) begin
                    state_nx = RECV;
                end
            end
            default: state_nx = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RECV;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            ph        <= '0;
            sweep     <= '0;
            k_r       <= '0;
            iter_used <= '0;
            tol_en_r  <= 1'b0;
            tol_r     <= '0;
            maxd      <= '0;
        end else begin
            unique case (state)
                RECV: begin
                    if (acc) begin
                        if (cnt == '0) begin
                            k_r       <= (bus.iter_cfg == 8'd0) ? 8'd1
                                                                : bus.iter_cfg;
                            tol_en_r  <= bus.tol_en;
                            tol_r     <= bus.tol;
                            iter_used <= '0;
                        end
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            ph    <= '0;
                            sweep <= 8'd1;
                            maxd  <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (wb) begin
                        ph <= '0;
                        if (last_u) begin
                            cnt <= '0;
                            if (fin) begin
                                iter_used <= sweep;
                            end else begin
                                sweep <= sweep + 8'd1;
                                maxd  <= '0;
                            end
                        end else begin
                            cnt  <= cnt + 1'b1;
                            maxd <= maxd_nx;
                        end
                    end else begin
                        ph <= ph + 2'd1;
                    end
                end
                SEND: begin
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (acc) begin
                b_mem[cnt] <= bus.b_in;
                x_mem[cnt] <= bx;
            end else if (wb) begin
                x_mem[cnt] <= x_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == CALC && ph == 2'd0) begin
            p1_r   <= XW1'(nl[0]) + XW1'(nh[0]);
            p2_r   <= XW1'(nl[1]) + XW1'(nh[1]);
            p3_r   <= XW1'(nl[2]) + XW1'(nh[2]);
            bsh_r  <= SW'(b_mem[cnt]) <<< FRAC;
            xold_r <= x_mem[cnt];
        end
        if (state == CALC && ph == 2'd1) begin
            prod_r <= PW'(s_sum) * PW'(KMUL);
        end
    end

    assign bus.busy      = (state != RECV);
    assign bus.out_valid = (state == SEND);
    assign bus.x_out     = (state == SEND) ? x_mem[cnt] : '0;
    assign bus.iter_used = iter_used;

endmodule
